// File: rtl/mem_access_unit.sv
// Load/store sequencer between the multicycle MIPS datapath and a word-addressed memory.
// Sub-word stores are performed as read-modify-write; WAIT_STATES stretches every read.

module mem_access_unit_chk (
    input logic clk,
    input logic rst,
    input logic busy,
    input logic done,
    input logic misaligned,
    input logic mem_read,
    input logic mem_write
);

    a_strobe_excl : assert property (@(posedge clk) disable iff (!rst)
        !(mem_read && mem_write));

    a_done_pulse : assert property (@(posedge clk) disable iff (!rst)
        done |=> !done);

    a_done_not_busy : assert property (@(posedge clk) disable iff (!rst)
        done |-> !busy);

    a_mis_with_done : assert property (@(posedge clk) disable iff (!rst)
        misaligned |-> done);

endmodule

module mem_access_unit #(
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        misaligned,
    output logic [31:0] rdata,
    output logic [31:0] memAddress,
    output logic [31:0] memWriteData,
    output logic        memRead,
    output logic        memWrite,
    input  logic [31:0] memReadData
);

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RD   = 2'b01,
        ST_WR   = 2'b10,
        ST_DONE = 2'b11
    } state_t;

    state_t      state_r;
    state_t      state_nx_s;

    logic [1:0]  size_r;
    logic        we_r;
    logic        sign_ext_r;
    logic [1:0]  lane_r;
    logic [31:0] wdata_r;
    logic        mis_r;
    logic [3:0]  wait_cnt_r;
    logic [31:0] rdata_r;
    logic [31:0] mem_address_r;
    logic [31:0] mem_write_data_r;

    logic        accept_s;
    logic        illegal_s;
    logic        rd_final_s;
    logic        word_store_s;

    // Pull the addressed byte/half out of a word and extend it.
    function automatic logic [31:0] extract_lane(
        input logic [31:0] word,
        input logic [1:0]  sz,
        input logic [1:0]  lane,
        input logic        sx
    );
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        b = 8'(word >> {lane, 3'b000});
        h = 16'(word >> {lane[1], 4'b0000});
        case (sz)
            SZ_BYTE: res = {{24{sx & b[7]}}, b};
            SZ_HALF: res = {{16{sx & h[15]}}, h};
            default: res = word;
        endcase
        return res;
    endfunction

    // Replace only the addressed lane of a word with the low bits of the store data.
    function automatic logic [31:0] merge_lane(
        input logic [31:0] word,
        input logic [31:0] wd,
        input logic [1:0]  sz,
        input logic [1:0]  lane
    );
        logic [31:0] mask;
        logic [31:0] ins;
        case (sz)
            SZ_BYTE: begin
                mask = 32'h0000_00FF << {lane, 3'b000};
                ins  = {24'h00_0000, wd[7:0]} << {lane, 3'b000};
            end
            SZ_HALF: begin
                mask = 32'h0000_FFFF << {lane[1], 4'b0000};
                ins  = {16'h0000, wd[15:0]} << {lane[1], 4'b0000};
            end
            default: begin
                mask = 32'hFFFF_FFFF;
                ins  = wd;
            end
        endcase
        return (word & ~mask) | (ins & mask);
    endfunction

    // Request decode: acceptance, alignment and final read cycle.
    always_comb begin
        accept_s     = 1'b0;
        illegal_s    = 1'b0;
        rd_final_s   = 1'b0;
        word_store_s = 1'b0;
        if (state_r == ST_IDLE) begin
            accept_s = req;
        end else begin
            accept_s = 1'b0;
        end
        case (size)
            SZ_BYTE: illegal_s = 1'b0;
            SZ_HALF: illegal_s = addr[0];
            SZ_WORD: illegal_s = (addr[1:0] != 2'b00);
            default: illegal_s = 1'b1;
        endcase
        if ((state_r == ST_RD) && (wait_cnt_r == 4'd0)) begin
            rd_final_s = 1'b1;
        end else begin
            rd_final_s = 1'b0;
        end
        if (we && (size == SZ_WORD)) begin
            word_store_s = 1'b1;
        end else begin
            word_store_s = 1'b0;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (!req) begin
                    state_nx_s = ST_IDLE;
                end else if (illegal_s) begin
                    state_nx_s = ST_DONE;
                end else if (word_store_s) begin
                    state_nx_s = ST_WR;
                end else begin
                    state_nx_s = ST_RD;
                end
            end
            ST_RD: begin
                if (wait_cnt_r != 4'd0) begin
                    state_nx_s = ST_RD;
                end else if (we_r) begin
                    state_nx_s = ST_WR;
                end else begin
                    state_nx_s = ST_DONE;
                end
            end
            ST_WR:   state_nx_s = ST_DONE;
            ST_DONE: state_nx_s = ST_IDLE;
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Latch the request on acceptance, including rejected ones.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            size_r        <= 2'b00;
            we_r          <= 1'b0;
            sign_ext_r    <= 1'b0;
            lane_r        <= 2'b00;
            wdata_r       <= 32'h0000_0000;
            mis_r         <= 1'b0;
            mem_address_r <= 32'h0000_0000;
        end else if (accept_s) begin
            size_r        <= size;
            we_r          <= we;
            sign_ext_r    <= sign_ext;
            lane_r        <= addr[1:0];
            wdata_r       <= wdata;
            mis_r         <= illegal_s;
            mem_address_r <= {addr[31:2], 2'b00};
        end
    end

    // Wait-state counter: loaded on acceptance, counts down in RD, saturates at zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt_r <= 4'd0;
        end else if (accept_s) begin
            wait_cnt_r <= WAIT_INIT;
        end else if ((state_r == ST_RD) && (wait_cnt_r != 4'd0)) begin
            wait_cnt_r <= wait_cnt_r - 4'd1;
        end
    end

    // Load result register; only a completed load updates it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata_r <= 32'h0000_0000;
        end else if (rd_final_s && !we_r) begin
            rdata_r <= extract_lane(memReadData, size_r, lane_r, sign_ext_r);
        end
    end

    // Write word: store data directly for word stores, merged word after the RMW read.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_write_data_r <= 32'h0000_0000;
        end else if (accept_s && !illegal_s && word_store_s) begin
            mem_write_data_r <= wdata;
        end else if (rd_final_s && we_r) begin
            mem_write_data_r <= merge_lane(memReadData, wdata_r, size_r, lane_r);
        end
    end

    // Strobes and status decoded straight from the state register so reset kills them at once.
    always_comb begin
        busy       = 1'b0;
        done       = 1'b0;
        misaligned = 1'b0;
        memRead    = 1'b0;
        memWrite   = 1'b0;
        case (state_r)
            ST_RD: begin
                busy    = 1'b1;
                memRead = 1'b1;
            end
            ST_WR: begin
                busy     = 1'b1;
                memWrite = 1'b1;
            end
            ST_DONE: begin
                done       = 1'b1;
                misaligned = mis_r;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    assign rdata        = rdata_r;
    assign memAddress   = mem_address_r;
    assign memWriteData = mem_write_data_r;

    mem_access_unit_chk u_chk (
        .clk        (clk),
        .rst        (rst),
        .busy       (busy),
        .done       (done),
        .misaligned (misaligned),
        .mem_read   (memRead),
        .mem_write  (memWrite)
    );

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: one instance with WAIT_STATES=0, one with WAIT_STATES=2,
// each backed by its own small word memory model.

module tb_mem_access_unit;

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        sx;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          lat;
        logic        mis;
        logic [31:0] rdata;
        int          rdc;
        int          wrc;
        logic [31:0] mem;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        we;
    logic [1:0]  size;
    logic        sign_ext;
    logic [31:0] addr;
    logic [31:0] wdata;

    logic        busy0, done0, mis0, memRead0, memWrite0;
    logic [31:0] rdata0, memAddress0, memWriteData0, memReadData0;
    logic        busy1, done1, mis1, memRead1, memWrite1;
    logic [31:0] rdata1, memAddress1, memWriteData1, memReadData1;

    logic [31:0] mem0 [64];
    logic [31:0] mem1 [64];

    logic        sel;
    logic        ld_en;
    logic        ld_sel;
    logic [5:0]  ld_idx;
    logic [31:0] ld_val;

    int total = 0;
    int passed = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.WAIT_STATES(0)) dut0 (
        .clk(clk), .rst(rst), .req(req), .we(we), .size(size), .sign_ext(sign_ext),
        .addr(addr), .wdata(wdata), .busy(busy0), .done(done0), .misaligned(mis0),
        .rdata(rdata0), .memAddress(memAddress0), .memWriteData(memWriteData0),
        .memRead(memRead0), .memWrite(memWrite0), .memReadData(memReadData0)
    );

    mem_access_unit #(.WAIT_STATES(2)) dut1 (
        .clk(clk), .rst(rst), .req(req), .we(we), .size(size), .sign_ext(sign_ext),
        .addr(addr), .wdata(wdata), .busy(busy1), .done(done1), .misaligned(mis1),
        .rdata(rdata1), .memAddress(memAddress1), .memWriteData(memWriteData1),
        .memRead(memRead1), .memWrite(memWrite1), .memReadData(memReadData1)
    );

    assign memReadData0 = mem0[memAddress0[7:2]];
    assign memReadData1 = mem1[memAddress1[7:2]];

    // Memory model: preload port plus write at the edge that ends a memWrite cycle.
    always @(posedge clk) begin
        if (ld_en) begin
            if (ld_sel) mem1[ld_idx] <= ld_val;
            else        mem0[ld_idx] <= ld_val;
        end else begin
            if (memWrite0) mem0[memAddress0[7:2]] <= memWriteData0;
            if (memWrite1) mem1[memAddress1[7:2]] <= memWriteData1;
        end
    end

    wire        m_busy    = sel ? busy1 : busy0;
    wire        m_done    = sel ? done1 : done0;
    wire        m_mis     = sel ? mis1 : mis0;
    wire        m_rd      = sel ? memRead1 : memRead0;
    wire        m_wr      = sel ? memWrite1 : memWrite0;
    wire [31:0] m_rdata   = sel ? rdata1 : rdata0;
    wire [31:0] m_addr    = sel ? memAddress1 : memAddress0;
    wire [31:0] m_wdata   = sel ? memWriteData1 : memWriteData0;

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s[%0d]: got %08h, expected %08h", name, idx, act, exp);
    endtask

    task automatic poke(input logic s, input logic [5:0] idx, input logic [31:0] val);
        ld_sel = s; ld_idx = idx; ld_val = val; ld_en = 1'b1;
        @(posedge clk); #1;
        ld_en = 1'b0;
    endtask

    task automatic check_all_zero(input int tag);
        check("rst_busy",  tag, 32'(m_busy), 32'd0);
        check("rst_done",  tag, 32'(m_done), 32'd0);
        check("rst_mis",   tag, 32'(m_mis), 32'd0);
        check("rst_memRead",  tag, 32'(m_rd), 32'd0);
        check("rst_memWrite", tag, 32'(m_wr), 32'd0);
        check("rst_rdata", tag, m_rdata, 32'h0000_0000);
        check("rst_memAddress", tag, m_addr, 32'h0000_0000);
        check("rst_memWriteData", tag, m_wdata, 32'h0000_0000);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int edges;
        int rdc;
        int wrc;
        logic [31:0] wd_seen;
        logic [31:0] mw;
        we = v.we; size = v.size; sign_ext = v.sx; addr = v.addr; wdata = v.wdata; req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
        edges = 1; rdc = 0; wrc = 0; wd_seen = 32'h0;
        while (!m_done && edges < 40) begin
            if (m_rd) begin
                rdc++;
                check("rd_addr", idx, m_addr, v.addr & 32'hFFFF_FFFC);
            end
            if (m_wr) begin
                wrc++;
                wd_seen = m_wdata;
            end
            @(posedge clk); #1;
            edges++;
        end
        mw = sel ? mem1[v.addr[7:2]] : mem0[v.addr[7:2]];
        check("latency",    idx, 32'(edges), 32'(v.lat));
        check("misaligned", idx, 32'(m_mis), 32'(v.mis));
        check("rdata",      idx, m_rdata, v.rdata);
        check("rd_cycles",  idx, 32'(rdc), 32'(v.rdc));
        check("wr_cycles",  idx, 32'(wrc), 32'(v.wrc));
        if (v.wrc != 0) check("memWriteData", idx, wd_seen, v.mem);
        check("memAddress", idx, m_addr, v.addr & 32'hFFFF_FFFC);
        check("busy_in_done", idx, 32'(m_busy), 32'd0);
        check("mem_word",   idx, mw, v.mem);
        @(posedge clk); #1;
    endtask

    vec_t vt [14];

    initial begin
        int dcount;
        int icount;

        //          we    size   sx    addr          wdata         lat mis   rdata         rdc wrc mem
        vt[0]  = '{1'b0, 2'b10, 1'b0, 32'h0000_0040, 32'h0,        2, 1'b0, 32'h8081_8283, 1, 0, 32'h8081_8283};
        vt[1]  = '{1'b0, 2'b00, 1'b1, 32'h0000_0043, 32'h0,        2, 1'b0, 32'hFFFF_FF80, 1, 0, 32'h8081_8283};
        vt[2]  = '{1'b0, 2'b00, 1'b0, 32'h0000_0041, 32'h0,        2, 1'b0, 32'h0000_0082, 1, 0, 32'h8081_8283};
        vt[3]  = '{1'b0, 2'b01, 1'b1, 32'h0000_0042, 32'h0,        2, 1'b0, 32'hFFFF_8081, 1, 0, 32'h8081_8283};
        vt[4]  = '{1'b0, 2'b01, 1'b0, 32'h0000_0040, 32'h0,        2, 1'b0, 32'h0000_8283, 1, 0, 32'h8081_8283};
        vt[5]  = '{1'b0, 2'b10, 1'b0, 32'h0000_0042, 32'h0,        1, 1'b1, 32'h0000_8283, 0, 0, 32'h8081_8283};
        vt[6]  = '{1'b1, 2'b01, 1'b0, 32'h0000_0045, 32'h0000_1234, 1, 1'b1, 32'h0000_8283, 0, 0, 32'h0000_0000};
        vt[7]  = '{1'b0, 2'b11, 1'b0, 32'h0000_0040, 32'h0,        1, 1'b1, 32'h0000_8283, 0, 0, 32'h8081_8283};
        vt[8]  = '{1'b1, 2'b00, 1'b0, 32'h0000_0041, 32'h0000_00AB, 5, 1'b0, 32'h0000_0000, 3, 1, 32'h1122_AB44};
        vt[9]  = '{1'b1, 2'b01, 1'b0, 32'h0000_0042, 32'h0000_BEEF, 5, 1'b0, 32'h0000_0000, 3, 1, 32'hBEEF_AB44};
        vt[10] = '{1'b1, 2'b10, 1'b0, 32'h0000_0044, 32'hCAFE_F00D, 2, 1'b0, 32'h0000_0000, 0, 1, 32'hCAFE_F00D};
        vt[11] = '{1'b0, 2'b00, 1'b1, 32'h0000_0047, 32'h0,        4, 1'b0, 32'hFFFF_FFCA, 3, 0, 32'hCAFE_F00D};
        vt[12] = '{1'b1, 2'b00, 1'b0, 32'h0000_0040, 32'h1234_5677, 5, 1'b0, 32'hFFFF_FFCA, 3, 1, 32'hBEEF_AB77};
        vt[13] = '{1'b0, 2'b10, 1'b0, 32'h0000_0040, 32'h0,        4, 1'b0, 32'hBEEF_AB77, 3, 0, 32'hBEEF_AB77};

        sel = 1'b0; rst = 1'b0; req = 1'b0; we = 1'b0; size = 2'b00; sign_ext = 1'b0;
        addr = 32'h0; wdata = 32'h0; ld_en = 1'b0; ld_sel = 1'b0; ld_idx = 6'd0; ld_val = 32'h0;

        poke(1'b0, 6'h10, 32'h8081_8283);
        poke(1'b0, 6'h11, 32'h0000_0000);
        poke(1'b1, 6'h10, 32'h1122_3344);
        poke(1'b1, 6'h11, 32'h0000_0000);
        poke(1'b1, 6'h20, 32'h5555_AAAA);
        check_all_zero(0);

        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) run_vec(i, vt[i]);

        // Back-to-back with req held: one access every three edges, DONE ignores req.
        we = 1'b0; size = 2'b10; sign_ext = 1'b0; addr = 32'h0000_0040; req = 1'b1;
        dcount = 0; icount = 0;
        for (int e = 0; e < 12; e++) begin
            @(posedge clk); #1;
            if (m_done) dcount++;
            if (!m_busy && !m_done) icount++;
        end
        req = 1'b0;
        check("b2b_done_pulses", 20, 32'(dcount), 32'd4);
        check("b2b_idle_cycles", 20, 32'(icount), 32'd4);
        check("b2b_rdata", 20, m_rdata, 32'h8081_8283);

        rst = 1'b0;
        @(posedge clk); #1;
        sel = 1'b1;
        check_all_zero(1);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;

        for (int i = 8; i < 14; i++) run_vec(i, vt[i]);

        // Reset in the middle of the WR cycle of a word store.
        we = 1'b1; size = 2'b10; sign_ext = 1'b0; addr = 32'h0000_0080; wdata = 32'hDEAD_BEEF; req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
        check("wr_before_rst", 30, 32'(m_wr), 32'd1);
        #2 rst = 1'b0;
        #1 check_all_zero(30);
        @(posedge clk); #1;
        check("mem_after_rst", 30, mem1[6'h20], 32'h5555_AAAA);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        run_vec(31, '{1'b0, 2'b10, 1'b0, 32'h0000_0080, 32'h0, 4, 1'b0, 32'h5555_AAAA, 3, 0, 32'h5555_AAAA});

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
